// File: rtl/sreg_pkg.sv
// rtl/sreg_pkg.sv - shared defaults and state type for the shift-register controller
package sreg_pkg;

    localparam int WIDTH_DEF = 42;
    localparam int OUT_W_DEF = 2;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sreg_model.sv
// rtl/sreg_model.sv - behavioural model of the external parallel-load shift register
module sreg_model
    import sreg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             sclk,
    input  logic             shift,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] pixel_in,
    output logic [OUT_W-1:0] sreg_out
);

    logic [WIDTH-1:0] sr_q;

    // The physical register has no reset pin; its content is only defined after a load.
    always_ff @(posedge sclk) begin
        if (shift) begin
            sr_q <= {sr_q[WIDTH-2:0], serial_in};
        end else begin
            sr_q <= pixel_in;
        end
    end

    assign sreg_out = sr_q[WIDTH-1:WIDTH-OUT_W];

endmodule

// File: rtl/sreg_ctrl.sv
// rtl/sreg_ctrl.sv - loads a pixel word into an external shift register and collects its serial output
module sreg_ctrl
    import sreg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [OUT_W-1:0] sreg_in,
    input  logic             ready,
    output logic             shift,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rx_data,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             unused_taps;

    assign unused_taps = ^sreg_in[OUT_W-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
            rx_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready;
            data_out_q <= data_out_d;
            rx_q       <= rx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        rx_d       = rx_q;
        unique case (state_q)
            IDLE: begin
                // Only a fresh rising edge starts a transfer; a held-high ready is ignored.
                if (ready && !ready_q) begin
                    state_d    = LOAD;
                    data_out_d = data_in;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                rx_d  = {rx_q[WIDTH-2:0], sreg_in[OUT_W-1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers so nothing on the inputs reaches them combinationally.
    assign shift    = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign data_out = data_out_q;
    assign rx_data  = rx_q;

endmodule

// File: tb/tb_sreg_ctrl.sv
// tb/tb_sreg_ctrl.sv - randomized self-checking bench for sreg_ctrl with the register model in the loop
module tb_sreg_ctrl;

    localparam int WIDTH = 42;
    localparam int OUT_W = 2;
    localparam logic [WIDTH-1:0] PIX = 42'h26B4B4F692A;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [OUT_W-1:0] sreg_in;
    logic             ready = 1'b0;
    logic             shift;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rx_data;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sreg_ctrl #(.WIDTH(WIDTH), .OUT_W(OUT_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .sreg_in  (sreg_in),
        .ready    (ready),
        .shift    (shift),
        .data_out (data_out),
        .rx_data  (rx_data),
        .done     (done)
    );

    sreg_model #(.WIDTH(WIDTH), .OUT_W(OUT_W)) u_model (
        .sclk      (clk),
        .shift     (shift),
        .serial_in (1'b0),
        .pixel_in  (data_out),
        .sreg_out  (sreg_in)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference timeline, counted in edges after ready rises: edge 1 captures the word,
    // one load cycle, WIDTH shift cycles, then a single done cycle.
    task automatic run_transfer(input logic [WIDTH-1:0] word, input bit hold, input bit corrupt);
        int n_cyc;
        int n_done;
        int n_shift;
        bit exp_shift;
        bit exp_done;
        n_cyc   = hold ? 100 : WIDTH + 3;
        n_done  = 0;
        n_shift = 0;
        @(negedge clk);
        data_in = word;
        ready   = 1'b1;
        for (int k = 1; k <= n_cyc; k++) begin
            @(posedge clk);
            #1;
            exp_shift = (k >= 2) && (k <= WIDTH + 1);
            exp_done  = (k == WIDTH + 2);
            if (k == 1) check("data_out_capture", 64'(data_out), 64'(word));
            if (k <= WIDTH + 3) begin
                check("shift_timeline", 64'(shift), 64'(exp_shift));
                check("done_timeline", 64'(done), 64'(exp_done));
            end
            if (k == WIDTH + 2) begin
                check("rx_data", 64'(rx_data), 64'(word));
                check("data_out_held", 64'(data_out), 64'(word));
                check("model_empty", 64'(u_model.sr_q), 64'(0));
            end
            n_done  += int'(done);
            n_shift += int'(shift);
            if (corrupt && k == 10) data_in = '0;
            if (!hold && k == 3) ready = 1'b0;
        end
        ready = 1'b0;
        check("done_pulses", 64'(n_done), 64'(1));
        check("shift_cycles", 64'(n_shift), 64'(WIDTH));
    endtask

    initial begin
        logic [63:0] rnd;
        int n_done;
        int n_shift;

        rst_n = 1'b0;
        repeat (42) @(posedge clk);
        #1;
        check("rst_shift", 64'(shift), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_rx_data", 64'(rx_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_transfer(PIX, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        run_transfer(PIX, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        run_transfer(PIX ^ 42'h3FF_0000_FFFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);

        // Abort in the 20th shift cycle; ready is already low so nothing may restart.
        @(negedge clk);
        data_in = PIX;
        ready   = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        check("pre_abort_shift", 64'(shift), 64'(1));
        ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_shift", 64'(shift), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_data_out", 64'(data_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_done  = 0;
        n_shift = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            n_done  += int'(done);
            n_shift += int'(shift);
        end
        check("abort_no_done", 64'(n_done), 64'(0));
        check("abort_no_shift", 64'(n_shift), 64'(0));

        for (int t = 0; t < 8; t++) begin
            rnd = {$urandom(), $urandom()};
            run_transfer(rnd[WIDTH-1:0], 1'b0, ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(1, 5)) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sreg_ctrl.md
SREG_CTRL -- requirements
Module: sreg_ctrl

Interface
REQ-001 Parameter: WIDTH, 42, pixel/shift-register length in bits.
REQ-002 Parameter: OUT_W, 2, width of shift-register tap bus.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 data_in  input  WIDTH  pixel word to transmit, sampled at start.
REQ-006 sreg_in  input  OUT_W  tap bus returned from shift register (bit 1 = serial output).
REQ-007 ready  input  1  start request; rising edge starts a transfer.
REQ-008 shift  output  1  shift enable to register; 0 = parallel load, 1 = shift.
REQ-009 data_out  output  WIDTH  held pixel word driven to register parallel input.
REQ-010 rx_data  output  WIDTH  word collected from sreg_in[1] during last transfer.
REQ-011 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-012 FSM states IDLE, LOAD, SHIFT, DONE; state register clocked by clk.
REQ-013 IDLE->LOAD when ready=1 and ready was 0 on previous cycle; data_out <= data_in on that edge.
REQ-014 ready held high after a transfer SHALL NOT start another; a new rising edge is required.
REQ-015 LOAD lasts exactly 1 cycle with shift=0 so the register loads data_out; then ->SHIFT.
REQ-016 SHIFT lasts exactly WIDTH cycles with shift=1; a 6-bit counter tracks cycles.
REQ-017 Each SHIFT-cycle edge: rx_data <= {rx_data[WIDTH-2:0], sreg_in[1]} (MSB first).
REQ-018 After the WIDTH-th shift edge ->DONE; done=1, shift=0 for 1 cycle; then ->IDLE.
REQ-019 shift decoded from state register only (=1 iff state==SHIFT); no combinational path from inputs.
REQ-020 data_out stable from LOAD through DONE; ready edges outside IDLE are ignored.
REQ-021 Latency ready rise -> done: 1 + 1 + WIDTH + 1 = 45 cycles for WIDTH=42.

Reset
REQ-022 rst_n=0 asynchronously forces state=IDLE, counter=0, shift=0, done=0, data_out=0, rx_data=0, ready history=0.
REQ-023 Reset mid-transfer aborts immediately; after release, ready must rise again to start.

Structure
REQ-024 Shared package sreg_pkg holds WIDTH/OUT_W defaults and the state enum type.
REQ-025 Companion sub-module sreg_model (ports sclk, shift, serial_in, pixel_in[WIDTH], sreg_out[OUT_W]) models the external register.
REQ-026 sreg_model: on sclk rise, shift=0 loads pixel_in; shift=1 does reg <= {reg[WIDTH-2:0], serial_in}; sreg_out = reg[WIDTH-1:WIDTH-2]; no reset.
REQ-027 Bench connects sreg_model.sclk=clk, shift, pixel_in=data_out, sreg_out->sreg_in, serial_in=0.

Verification
REQ-028 Reset: hold rst_n=0 42 cycles -> shift=0, done=0, data_out=0, rx_data=0.
REQ-029 data_in=42'h26B4B4F692A, ready rises -> data_out=42'h26B4B4F692A next cycle; shift=0 1 cycle, then 1 for exactly 42 cycles.
REQ-030 Same transfer -> done pulses at cycle 45 after ready rise; rx_data=42'h26B4B4F692A; model register = 0 (serial_in=0).
REQ-031 Hold ready=1 for 100 cycles -> exactly one transfer and one done pulse.
REQ-032 Drop rst_n for 1 cycle at shift cycle 20 -> shift=0 at once, state IDLE, no done pulse.
REQ-033 Change data_in during SHIFT to 42'h0 -> data_out and rx_data unaffected (still 42'h26B4B4F692A).
